// File: rtl/uart_frame_parser.sv
// ---------------------------------------------------------------------------
// uart_frame_parser
//
// Assembles bytes from a UART receiver into 15-byte command frames:
//   HEAD, FUNC, D1..D11, CSUM, TAIL
//
// The frame is validated in three ways:
//   - the header must match HEAD_BYTE,
//   - CSUM must equal (FUNC + D1 + ... + D11) mod 256,
//   - the tail must match TAIL_BYTE.
//
// On a good frame, the registered outputs are loaded from the shadow copy and
// pack_done pulses for one cycle. Frames with a bad checksum, a bad tail, or a
// stall between bytes are dropped, and the matching error strobe pulses.
//
// Ports
//   clk_50M                in   system clock
//   rst_n                  in   synchronous reset, active low
//   rx_data[7:0]           in   byte from the UART receiver
//   rx_done                in   1-cycle strobe, rx_data valid
//   func_reg[7:0]          out  function code of the last good frame
//   rev_data1..11[7:0]     out  payload bytes of the last good frame
//   pack_done              out  1-cycle strobe, outputs hold a new good frame
//   csum_err               out  1-cycle strobe, frame dropped on checksum
//   frame_err              out  1-cycle strobe, frame dropped on tail/timeout
// ---------------------------------------------------------------------------
module uart_frame_parser #(
    parameter logic [7:0] HEAD_BYTE   = 8'hAA,
    parameter logic [7:0] TAIL_BYTE   = 8'h55,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] func_reg,
    output logic [7:0] rev_data1,
    output logic [7:0] rev_data2,
    output logic [7:0] rev_data3,
    output logic [7:0] rev_data4,
    output logic [7:0] rev_data5,
    output logic [7:0] rev_data6,
    output logic [7:0] rev_data7,
    output logic [7:0] rev_data8,
    output logic [7:0] rev_data9,
    output logic [7:0] rev_data10,
    output logic [7:0] rev_data11,
    output logic       pack_done,
    output logic       csum_err,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    // The counter holds the number of idle cycles already seen. The limit is
    // reached on the cycle that would be the TIMEOUT_CYC-th idle cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FUNC,
        S_DATA,
        S_CSUM,
        S_TAIL
    } state_t;

    state_t           state_reg, state_next;
    logic [7:0]       acc_reg, acc_next;
    logic [3:0]       idx_reg, idx_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             pack_reg, pack_next;
    logic             csum_reg, csum_next;
    logic             frame_reg, frame_next;

    // Shadow entry 0 holds FUNC; entries 1..11 hold D1..D11.
    logic [7:0]       shadow_reg [0:11];
    logic [7:0]       hold_reg   [0:11];
    logic             shadow_we;
    logic [3:0]       shadow_addr;
    logic             load_out;

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            acc_reg   <= 8'd0;
            idx_reg   <= 4'd0;
            cnt_reg   <= '0;
            pack_reg  <= 1'b0;
            csum_reg  <= 1'b0;
            frame_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            pack_reg  <= pack_next;
            csum_reg  <= csum_next;
            frame_reg <= frame_next;
        end
    end

    // The shadow contents are only ever observed through hold_reg after a
    // complete good frame, so they need no reset.
    always_ff @(posedge clk_50M) begin
        if (shadow_we) begin
            shadow_reg[shadow_addr] <= rx_data;
        end
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            for (int i = 0; i < 12; i++) begin
                hold_reg[i] <= 8'd0;
            end
        end else if (load_out) begin
            for (int i = 0; i < 12; i++) begin
                hold_reg[i] <= shadow_reg[i];
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        idx_next    = idx_reg;
        cnt_next    = cnt_reg;
        pack_next   = 1'b0;
        csum_next   = 1'b0;
        frame_next  = 1'b0;
        shadow_we   = 1'b0;
        shadow_addr = idx_reg;
        load_out    = 1'b0;

        if (rx_done) begin
            // An accepted byte always restarts the inter-byte timer, which
            // also cancels a timeout that would otherwise fire this cycle.
            cnt_next = '0;
            case (state_reg)
                S_IDLE: begin
                    if (rx_data == HEAD_BYTE) begin
                        state_next = S_FUNC;
                    end
                end
                S_FUNC: begin
                    shadow_we   = 1'b1;
                    shadow_addr = 4'd0;
                    acc_next    = rx_data;
                    idx_next    = 4'd1;
                    state_next  = S_DATA;
                end
                S_DATA: begin
                    shadow_we = 1'b1;
                    acc_next  = acc_reg + rx_data;
                    if (idx_reg == 4'd11) begin
                        idx_next   = 4'd0;
                        state_next = S_CSUM;
                    end else begin
                        idx_next = idx_reg + 4'd1;
                    end
                end
                S_CSUM: begin
                    if (rx_data == acc_reg) begin
                        state_next = S_TAIL;
                    end else begin
                        csum_next  = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                S_TAIL: begin
                    if (rx_data == TAIL_BYTE) begin
                        load_out  = 1'b1;
                        pack_next = 1'b1;
                    end else begin
                        frame_next = 1'b1;
                    end
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end else if (state_reg != S_IDLE) begin
            if (cnt_reg >= CNT_LAST) begin
                frame_next = 1'b1;
                state_next = S_IDLE;
                cnt_next   = '0;
                acc_next   = 8'd0;
                idx_next   = 4'd0;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end else begin
            cnt_next = '0;
        end
    end

    assign func_reg   = hold_reg[0];
    assign rev_data1  = hold_reg[1];
    assign rev_data2  = hold_reg[2];
    assign rev_data3  = hold_reg[3];
    assign rev_data4  = hold_reg[4];
    assign rev_data5  = hold_reg[5];
    assign rev_data6  = hold_reg[6];
    assign rev_data7  = hold_reg[7];
    assign rev_data8  = hold_reg[8];
    assign rev_data9  = hold_reg[9];
    assign rev_data10 = hold_reg[10];
    assign rev_data11 = hold_reg[11];
    assign pack_done  = pack_reg;
    assign csum_err   = csum_reg;
    assign frame_err  = frame_reg;

endmodule

// File: tb/tb_uart_frame_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_parser
//
// Cycle-level check of uart_frame_parser against a byte-queue reference
// model. The model collects the bytes of a frame in a queue, judges the
// checksum and tail from the frame rules, and counts idle cycles for the
// timeout. After every clock edge, all outputs are compared with the model.
// ---------------------------------------------------------------------------
module tb_uart_frame_parser;

    localparam int TO = 200;

    logic       clk_50M = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_done = 1'b0;
    logic [7:0] func_reg;
    logic [7:0] rev_data1, rev_data2, rev_data3, rev_data4, rev_data5, rev_data6;
    logic [7:0] rev_data7, rev_data8, rev_data9, rev_data10, rev_data11;
    logic       pack_done, csum_err, frame_err;

    always #10 clk_50M = ~clk_50M;

    uart_frame_parser #(
        .HEAD_BYTE  (8'hAA),
        .TAIL_BYTE  (8'h55),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk_50M   (clk_50M),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .func_reg  (func_reg),
        .rev_data1 (rev_data1),
        .rev_data2 (rev_data2),
        .rev_data3 (rev_data3),
        .rev_data4 (rev_data4),
        .rev_data5 (rev_data5),
        .rev_data6 (rev_data6),
        .rev_data7 (rev_data7),
        .rev_data8 (rev_data8),
        .rev_data9 (rev_data9),
        .rev_data10(rev_data10),
        .rev_data11(rev_data11),
        .pack_done (pack_done),
        .csum_err  (csum_err),
        .frame_err (frame_err)
    );

    logic [7:0] obs_out [12];
    assign obs_out[0]  = func_reg;
    assign obs_out[1]  = rev_data1;
    assign obs_out[2]  = rev_data2;
    assign obs_out[3]  = rev_data3;
    assign obs_out[4]  = rev_data4;
    assign obs_out[5]  = rev_data5;
    assign obs_out[6]  = rev_data6;
    assign obs_out[7]  = rev_data7;
    assign obs_out[8]  = rev_data8;
    assign obs_out[9]  = rev_data9;
    assign obs_out[10] = rev_data10;
    assign obs_out[11] = rev_data11;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [7:0] frame_q [$];
    int         idle_cnt = 0;
    logic [7:0] m_out [12];
    logic       m_pack, m_csum, m_frame;
    int         n_good = 0, n_csum = 0, n_frame = 0;

    // Frame under construction for stimulus.
    logic [7:0] fr [15];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d, input bit r);
        int s;
        m_pack  = 1'b0;
        m_csum  = 1'b0;
        m_frame = 1'b0;
        if (!r) begin
            frame_q.delete();
            idle_cnt = 0;
            for (int i = 0; i < 12; i++) m_out[i] = 8'd0;
        end else if (v) begin
            idle_cnt = 0;
            if (frame_q.size() == 0) begin
                if (d == 8'hAA) frame_q.push_back(d);
            end else begin
                frame_q.push_back(d);
                if (frame_q.size() == 14) begin
                    s = 0;
                    for (int i = 1; i <= 12; i++) s += int'(frame_q[i]);
                    if ((s % 256) != int'(frame_q[13])) begin
                        m_csum = 1'b1;
                        frame_q.delete();
                    end
                end else if (frame_q.size() == 15) begin
                    if (d == 8'h55) begin
                        for (int i = 0; i < 12; i++) m_out[i] = frame_q[i + 1];
                        m_pack = 1'b1;
                    end else begin
                        m_frame = 1'b1;
                    end
                    frame_q.delete();
                end
            end
        end else if (frame_q.size() != 0) begin
            idle_cnt++;
            if (idle_cnt == TO) begin
                m_frame = 1'b1;
                frame_q.delete();
                idle_cnt = 0;
            end
        end
    endtask

    // One clock cycle: drive inputs, advance the model, compare everything.
    task automatic cycle(input bit v, input logic [7:0] d, input bit r);
        rst_n   = r;
        rx_done = v;
        rx_data = d;
        @(posedge clk_50M);
        #1;
        model_edge(v, d, r);
        check_val("pack_done", pack_done, m_pack);
        check_val("csum_err", csum_err, m_csum);
        check_val("frame_err", frame_err, m_frame);
        for (int i = 0; i < 12; i++) check_val($sformatf("out%0d", i), obs_out[i], m_out[i]);
        if (m_pack) begin
            n_good++;
            $display("frame good   func=%02h d1=%02h d11=%02h", m_out[0], m_out[1], m_out[11]);
        end
        if (m_csum) begin
            n_csum++;
            $display("frame csum error dropped");
        end
        if (m_frame) begin
            n_frame++;
            $display("frame tail/timeout error dropped");
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        cycle(1'b1, b, 1'b1);
        idle(gap);
    endtask

    task automatic fix_csum();
        int s;
        s = 0;
        for (int i = 1; i <= 12; i++) s += int'(fr[i]);
        fr[13] = 8'(s);
    endtask

    task automatic send_frame(input int first, input int last, input int gap_max);
        for (int i = first; i <= last; i++) send_byte(fr[i], $urandom_range(0, gap_max));
    endtask

    task automatic load_test1();
        fr = '{8'hAA, 8'h01, 8'h01, 8'h02, 8'h0A, 8'h00, 8'h10, 8'h03,
               8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h55};
        fix_csum();
    endtask

    int good_before;
    int kind;
    int k;

    initial begin
        for (int i = 0; i < 12; i++) m_out[i] = 8'd0;

        // Reset state.
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        idle(3);

        // 1: reference frame.
        load_test1();
        send_frame(0, 14, 0);
        idle(2);
        check_val("t1_func", func_reg, 8'h01);
        check_val("t1_d1", rev_data1, 8'h01);
        check_val("t1_d4", rev_data4, 8'h00);
        check_val("t1_d5", rev_data5, 8'h10);
        check_val("t1_d10", rev_data10, 8'h01);
        check_val("t1_count", n_good, 1);

        // 2: bad checksum.
        load_test1();
        fr[13] = fr[13] + 8'd1;
        send_frame(0, 14, 1);
        idle(2);
        check_val("t2_csum", n_csum, 1);
        check_val("t2_hold", rev_data5, 8'h10);

        // 3: bad tail.
        load_test1();
        fr[14] = 8'h56;
        send_frame(0, 14, 0);
        idle(2);
        check_val("t3_frame", n_frame, 1);

        // 4: stall after AA 02, then a good frame.
        send_byte(8'hAA, 0);
        send_byte(8'h02, 0);
        idle(TO + 3);
        check_val("t4_timeout", n_frame, 2);
        load_test1();
        send_frame(0, 14, 0);
        idle(1);

        // Byte on the limit cycle is accepted.
        load_test1();
        send_byte(fr[0], 0);
        send_byte(fr[1], TO - 1);
        send_frame(2, 14, 0);
        idle(1);
        check_val("t4_limit", n_good, 3);

        // 5: garbage before a frame, AA/55 inside the payload.
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h55, 0);
        load_test1();
        fr[1] = 8'h55;
        fr[3] = 8'hAA;
        fr[8] = 8'h55;
        fix_csum();
        send_frame(0, 14, 0);
        idle(1);
        check_val("t5_count", n_good, 4);
        check_val("t5_d2", rev_data2, 8'hAA);

        // 6: reset after byte 7, then the rest, then a full frame.
        load_test1();
        send_frame(0, 6, 0);
        cycle(1'b0, 8'h00, 1'b0);
        send_frame(7, 14, 0);
        idle(2);
        check_val("t6_cleared", func_reg, 8'h00);
        load_test1();
        send_frame(0, 14, 0);
        idle(1);
        check_val("t6_func", func_reg, 8'h01);

        // Randomized frames, including back-to-back arrival and gap boundaries.
        for (int f = 0; f < 60; f++) begin
            fr[0] = 8'hAA;
            for (int i = 1; i <= 12; i++) fr[i] = 8'($urandom);
            fix_csum();
            fr[14] = 8'h55;
            kind = $urandom_range(0, 9);
            if (kind == 0) fr[13] = fr[13] + 8'($urandom_range(1, 255));
            if (kind == 1) fr[14] = 8'h55 ^ 8'($urandom_range(1, 255));
            if (kind == 2) begin
                k = $urandom_range(1, 13);
                send_frame(0, k, 1);
                idle(TO + $urandom_range(0, 2));
            end else if (kind == 3) begin
                k = $urandom_range(1, 13);
                send_frame(0, 14, 0);
                send_byte(fr[0], 0);
                fr[0] = 8'hAA;
            end else if (kind == 4) begin
                // One inter-byte gap sitting right at the limit, either side.
                k = $urandom_range(1, 13);
                send_frame(0, k - 1, 0);
                send_byte(fr[k], TO - 1 + $urandom_range(0, 1));
                send_frame(k + 1, 14, 0);
            end else begin
                send_frame(0, 14, (f % 3 == 0) ? 0 : 3);
            end
        end
        idle(TO + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50ms;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
